// File: rtl/gearbox_pkg.sv
// Shared helpers for the gearbox FIFO: width derivations, packing-order
// slice selection and parameter legality checks.
package gearbox_pkg;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer addressing depth entries (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Slice that beat number idx lands in, given the packing order.
  function automatic int slice_idx(input int idx, input int ratio, input bit low_first);
    return low_first ? idx : (ratio - 1 - idx);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Legal configurations: power-of-two depth of at least two, ratio >= 2.
  function automatic bit params_ok(input int depth, input int ratio);
    return is_pow2(depth) && (depth >= 2) && (ratio >= 2);
  endfunction

endpackage

// File: rtl/beat_packer.sv
// Collects RATIO narrow beats into one wide word in the selected order.
// word_valid pulses on the final beat's acceptance with the complete word.
module beat_packer
  import gearbox_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  accept,
  input  logic [IN_W-1:0]       in_data,
  output logic [IN_W*RATIO-1:0] word,
  output logic                  word_valid,
  output logic                  partial
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IDX_W = $clog2(RATIO);

  logic [IDX_W-1:0] idx_reg;
  logic [OUT_W-1:0] pack_reg;
  logic [OUT_W-1:0] merged;
  logic [IDX_W-1:0] sel;
  logic             last_beat;

  assign sel       = IDX_W'(slice_idx(int'(idx_reg), RATIO, LOW_FIRST));
  assign last_beat = (idx_reg == IDX_W'(RATIO - 1));

  // Current packing register with the incoming beat dropped into its slice.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign merged[gi*IN_W +: IN_W] = (sel == IDX_W'(gi)) ? in_data
                                                           : pack_reg[gi*IN_W +: IN_W];
  end

  assign word       = merged;
  assign word_valid = accept & last_beat;
  assign partial    = (idx_reg != '0);

  // Beat index and packing register; a completed word restarts from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg  <= '0;
      pack_reg <= '0;
    end else if (flush) begin
      idx_reg  <= '0;
      pack_reg <= '0;
    end else if (accept) begin
      if (last_beat) begin
        idx_reg  <= '0;
        pack_reg <= '0;
      end else begin
        idx_reg  <= idx_reg + 1'b1;
        pack_reg <= merged;
      end
    end
  end

endmodule

// File: rtl/gearbox_fifo.sv
// Width-converting FIFO: packs RATIO input beats per word, stores up to
// DEPTH words and presents the head word show-ahead. Occupancy is tracked
// by an explicit count so full/empty never depend on pointer equality.
module gearbox_fifo
  import gearbox_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 8,
  parameter bit LOW_FIRST = 1'b1,
  parameter int AF_LEVEL  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [IN_W*RATIO-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [cnt_w(DEPTH)-1:0]       count,
  output logic                          almost_full,
  output logic                          partial
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  if (!params_ok(DEPTH, RATIO)) begin : g_bad_params
    $error("gearbox_fifo: DEPTH must be a power of two >= 2 and RATIO >= 2");
  end

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [OUT_W-1:0] word;
  logic             word_valid;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;

  // Ready depends only on registered occupancy; flush keeps the input open
  // because whatever is offered that cycle is dropped anyway.
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign in_ready  = flush | ~full;
  assign accept    = in_valid & in_ready & ~flush;
  assign push      = word_valid;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready & ~flush;

  assign out_data    = out_valid ? mem[rd_ptr_reg] : '0;
  assign count       = count_reg;
  assign almost_full = (int'(count_reg) >= AF_LEVEL);

  beat_packer #(
    .IN_W      (IN_W),
    .RATIO     (RATIO),
    .LOW_FIRST (LOW_FIRST)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid),
    .partial    (partial)
  );

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Word storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= word;
    end
  end

  // Pointers and count, with flush taking priority over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_reg <= CNT_W'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && count_reg == '0));

endmodule

// File: tb/tb_gearbox_fifo.sv
// Randomised and directed bench for gearbox_fifo against a queue-based model.
module tb_gearbox_fifo;

  localparam int IN_W  = 4;
  localparam int RATIO = 2;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;

  logic             in_ready, out_valid, almost_full, partial;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] count;

  logic             ms_in_ready, ms_out_valid, ms_almost_full, ms_partial;
  logic [OUT_W-1:0] ms_out_data;
  logic [CNT_W-1:0] ms_count;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [OUT_W-1:0] q_lo[$];
  logic [OUT_W-1:0] q_hi[$];
  logic [IN_W-1:0]  beats[$];

  always #5 clk = ~clk;

  gearbox_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .LOW_FIRST(1'b1), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .partial(partial));

  gearbox_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .LOW_FIRST(1'b0), .AF_LEVEL(AF)) dut_ms (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ms_in_ready), .out_data(ms_out_data), .out_valid(ms_out_valid), .out_ready(out_ready),
    .count(ms_count), .almost_full(ms_almost_full), .partial(ms_partial));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model's current state.
  task automatic check_outputs(input string tag);
    int n;
    n = q_lo.size();
    check_eq({tag, ".in_ready"},    32'(in_ready),    32'(flush || n != DEPTH));
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'(n != 0));
    check_eq({tag, ".out_data"},    32'(out_data),    (n != 0) ? 32'(q_lo[0]) : 32'd0);
    check_eq({tag, ".count"},       32'(count),       32'(n));
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
    check_eq({tag, ".partial"},     32'(partial),     32'(beats.size() != 0));
    check_eq({tag, ".ms_out_data"}, 32'(ms_out_data), (n != 0) ? 32'(q_hi[0]) : 32'd0);
    check_eq({tag, ".ms_count"},    32'(ms_count),    32'(n));
    check_eq({tag, ".ms_partial"},  32'(ms_partial),  32'(beats.size() != 0));
    check_eq({tag, ".ms_in_ready"}, 32'(ms_in_ready), 32'(flush || n != DEPTH));
    check_eq({tag, ".ms_out_valid"},32'(ms_out_valid),32'(n != 0));
    check_eq({tag, ".ms_af"},       32'(ms_almost_full), 32'(n >= AF));
  endtask

  task automatic model_clear();
    q_lo.delete();
    q_hi.delete();
    beats.delete();
  endtask

  // One clock edge of the FIFO's behaviour, from the current inputs.
  task automatic model_step();
    bit rdy;
    logic [OUT_W-1:0] lo, hi;
    if (flush) begin
      model_clear();
    end else begin
      rdy = (q_lo.size() != DEPTH);
      if (out_ready && q_lo.size() > 0) begin
        void'(q_lo.pop_front());
        void'(q_hi.pop_front());
      end
      if (in_valid && rdy) begin
        beats.push_back(in_data);
        if (beats.size() == RATIO) begin
          lo = '0;
          hi = '0;
          for (int i = 0; i < RATIO; i++) begin
            lo = lo | (OUT_W'(beats[i]) << (i * IN_W));
            hi = hi | (OUT_W'(beats[i]) << ((RATIO - 1 - i) * IN_W));
          end
          q_lo.push_back(lo);
          q_hi.push_back(hi);
          beats.delete();
        end
      end
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, advance model and clock.
  task automatic cycle(input string tag, input bit iv, input logic [IN_W-1:0] d,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_outputs(tag);
    $display("cyc %-8s iv=%0b d=%h ordy=%0b fl=%0b | rdy=%0b ov=%0b od=%h ms=%h cnt=%0d af=%0b part=%0b",
             tag, iv, d, ordy, fl, in_ready, out_valid, out_data, ms_out_data, count, almost_full, partial);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    check_eq("reset.out_data", 32'(out_data), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Two beats form one word in each packing order.
    cycle("t1b0", 1'b1, 4'hA, 1'b0, 1'b0);
    check_eq("t1.partial_mid", 32'(partial), 32'd1);
    check_eq("t1.valid_mid", 32'(out_valid), 32'd0);
    cycle("t1b1", 1'b1, 4'h5, 1'b0, 1'b0);
    check_eq("t1.data_lo", 32'(out_data), 32'h5A);
    check_eq("t1.data_ms", 32'(ms_out_data), 32'hA5);
    check_eq("t1.valid", 32'(out_valid), 32'd1);
    check_eq("t1.count", 32'(count), 32'd1);
    check_eq("t1.partial", 32'(partial), 32'd0);
    cycle("t1drn", 1'b0, 4'h0, 1'b1, 1'b0);

    // Fill to full, offer a held beat, then drain in order.
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 4'(i), 1'b0, 1'b0);
    check_eq("fill.count", 32'(count), 32'd8);
    check_eq("fill.in_ready", 32'(in_ready), 32'd0);
    check_eq("fill.af", 32'(almost_full), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check_eq("drain.word", 32'(out_data), 32'(((2 * k + 1) << 4) | (2 * k)));
      cycle("drain", 1'b1, 4'h7, 1'b1, 1'b0);
      if (k == 0) check_eq("drain.in_ready", 32'(in_ready), 32'd1);
    end
    repeat (3) cycle("idle", 1'b0, 4'h0, 1'b1, 1'b0);

    // Continuous streaming, pointers wrap.
    for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 4'(i), 1'b1, 1'b0);
    repeat (2) cycle("sdrain", 1'b0, 4'h0, 1'b1, 1'b0);

    // One word plus a partial, then flush with a beat offered.
    cycle("fl0", 1'b1, 4'h3, 1'b0, 1'b0);
    cycle("fl1", 1'b1, 4'h4, 1'b0, 1'b0);
    cycle("fl2", 1'b1, 4'h6, 1'b0, 1'b0);
    cycle("flush", 1'b1, 4'hF, 1'b0, 1'b1);
    check_eq("flush.count", 32'(count), 32'd0);
    check_eq("flush.valid", 32'(out_valid), 32'd0);
    check_eq("flush.partial", 32'(partial), 32'd0);
    cycle("pf0", 1'b1, 4'h1, 1'b0, 1'b0);
    cycle("pf1", 1'b1, 4'h2, 1'b0, 1'b0);
    check_eq("postflush.data", 32'(out_data), 32'h21);
    cycle("pfdrn", 1'b0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-word with a stored word present.
    cycle("ar0", 1'b1, 4'h1, 1'b0, 1'b0);
    cycle("ar1", 1'b1, 4'h2, 1'b0, 1'b0);
    cycle("ar2", 1'b1, 4'h3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_eq("arst.valid", 32'(out_valid), 32'd0);
    check_eq("arst.data", 32'(out_data), 32'd0);
    check_eq("arst.count", 32'(count), 32'd0);
    check_eq("arst.partial", 32'(partial), 32'd0);
    check_eq("arst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle("postrst", 1'b0, 4'h0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
